i2c_telemetry_target: RTL and testbench
=======================================

Name: i2c_telemetry_target

Overview:
I2C target (slave) that lets an external host (ground-station MCU or bench adapter) read a snapshot of flight telemetry over a two-wire bus and write one control byte. It is the responder end of the same protocol whose initiator the IMU driver implements. It sits beside the flight pipeline in drone2, samples packed telemetry bytes from the top level, and drives an open-drain SDA enable. It never drives SCL (no clock stretching).

Parameters:
TARGET_ADDR, 7'h42, 7-bit bus address the block responds to
NUM_REGS, 16, number of readable byte registers (addresses 0..NUM_REGS-1), max 128
CTRL_ADDR, 8'h0F, register address that accepts host writes
FILTER_LEN, 4, consecutive identical sys_clk samples required to accept an SCL/SDA level change

Ports:
sys_clk  input  1  system clock (38 MHz oscillator)
reset  input  1  synchronous, active-high reset
scl_in  input  1  raw SCL pin level
sda_in  input  1  raw SDA pin level
sda_drive_low  output  1  1 = pull SDA low (open-drain enable); 0 = release
reg_data_in  input  8*NUM_REGS  packed telemetry; byte k = bits [8k+7:8k]
ctrl_reg  output  8  last byte the host wrote to CTRL_ADDR
ctrl_strobe  output  1  one-cycle pulse when ctrl_reg updates
busy  output  1  high from accepted START until STOP or abort

Behaviour:
- Clock: one clock, sys_clk. Reset: synchronous, active-high, named reset.
- Reset values: sda_drive_low=0, ctrl_reg=8'h00, ctrl_strobe=0, busy=0, pointer=0, state IDLE.
- Input path: 2-flop synchronizer on each pin, then FILTER_LEN glitch filter. Filtered levels scl_f/sda_f feed edge detectors (scl_rise, scl_fall). Pin-to-decision latency = 2+FILTER_LEN cycles.
- START: sda_f falls while scl_f high. STOP: sda_f rises while scl_f high. Both are detected in any state. START (including repeated START) goes to ADDR with bit counter 0. STOP goes to IDLE and releases SDA.
- Snapshot: on every START, latch all of reg_data_in into an internal shadow. Reads return shadow bytes, so multi-byte values are coherent.
- Shifting: sample SDA on scl_rise, MSB first. Drive SDA changes only on scl_fall.
- States:
  IDLE: SDA released, busy=0.
  ADDR: shift 8 bits (7 address + R/W). On the 8th scl_fall: address match -> ADDR_ACK with SDA driven low. No match -> IDLE (ignore until next START).
  ADDR_ACK: release SDA or load the first read bit on the next scl_fall. R/W=0 -> WR_PTR. R/W=1 -> RD_DATA with shadow[pointer] loaded.
  WR_PTR: receive 8 bits, ACK, set pointer. Then WR_DATA.
  WR_DATA: receive a byte and ACK it. If pointer==CTRL_ADDR, update ctrl_reg and pulse ctrl_strobe for one cycle on the ACK scl_fall. Other addresses are ACKed and discarded. Pointer increments after each byte.
  RD_DATA: shift out the byte. On the 8th scl_fall release SDA -> RD_ACK.
  RD_ACK: sample host ACK on scl_rise. ACK (0): pointer++ and load the next byte -> RD_DATA. NACK (1): -> WAIT_STOP (SDA released).
- Pointer: 8-bit. Increments wrap to 0 at NUM_REGS. A pointer value >= NUM_REGS written by the host is clamped to 0. Reads of an out-of-range address cannot occur.
- Master ACK window: SDA is released whenever the host owns the bit. sda_drive_low is never asserted during a host-owned bit.
- busy: 1 from the cycle START is accepted with an address match (set at ADDR entry, cleared if no match) until STOP.
- Reset mid-transfer: reset takes effect on the next sys_clk edge. SDA is released immediately. The transaction in flight is abandoned, and the block stays in IDLE until a fresh START.
- Simultaneous: ctrl_strobe and a new START in the same cycle: the strobe still fires and ctrl_reg holds the written value.

Test Plan:
1. Reset asserted 3 cycles -> sda_drive_low=0, ctrl_reg=00, busy=0. Bus idle high for 100 us -> no response.
2. START, 0x84 (addr 0x42 write), 0x03, repeated START, 0x85, read 3 bytes ACK,ACK,NACK, STOP with reg bytes 3..5 = A1,B2,C3 -> target ACKs address and pointer, returns A1,B2,C3, releases SDA after NACK, busy falls at STOP.
3. START, 0x84, 0x0F, 0x5A, STOP -> all ACKed, ctrl_reg=5A, exactly one ctrl_strobe pulse.
4. START, 0x86 (addr 0x43) -> NACK (SDA never driven), busy=0, following bytes ignored.
5. Pointer=0x0E, read 3 bytes -> returns bytes 14, 15, 0 (wrap). Changing reg_data_in mid-read does not alter returned data.
6. 50 ns glitch on SCL during a read -> no bit slip. Reset asserted mid-byte -> SDA released next cycle. Next transaction from item 2 passes.

Source files
------------

// File: rtl/i2c_telemetry_target.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2c_telemetry_target
//
// I2C target that lets an external host read a coherent snapshot of packed
// telemetry bytes and write a single control byte. SCL is only observed,
// never driven (no clock stretching). SDA is driven through an open-drain
// enable.
//
// Ports:
//   sys_clk        system clock
//   reset          synchronous, active-high reset
//   scl_in         raw SCL pin level
//   sda_in         raw SDA pin level
//   sda_drive_low  1 = pull SDA low, 0 = release
//   reg_data_in    packed telemetry, byte k = bits [8k+7:8k]
//   ctrl_reg       last byte the host wrote to CTRL_ADDR
//   ctrl_strobe    one-cycle pulse when ctrl_reg updates
//   busy           high from an accepted, address-matched START until STOP
// ----------------------------------------------------------------------------
module i2c_telemetry_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] CTRL_ADDR   = 8'h0F,
    parameter int         FILTER_LEN  = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_drive_low,
    input  logic [8*NUM_REGS-1:0] reg_data_in,
    output logic [7:0]            ctrl_reg,
    output logic                  ctrl_strobe,
    output logic                  busy
);

    localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int                FCNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [7:0]        PTR_LAST  = 8'(NUM_REGS - 1);
    localparam logic [8:0]        PTR_LIMIT = 9'(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_PTR, PTR_ACK, WR_DATA, DATA_ACK,
        RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == PTR_LAST) ? 8'd0 : p + 8'd1;
    endfunction

    // Host-written pointers outside the register file fold back to 0.
    function automatic logic [7:0] ptr_clamp(input logic [7:0] p);
        return ({1'b0, p} >= PTR_LIMIT) ? 8'd0 : p;
    endfunction

    state_t              state, state_next;
    logic                scl_p0, scl_p1, sda_p0, sda_p1;
    logic [FCNT_W-1:0]   scl_cnt, sda_cnt;
    logic                scl_f, sda_f, scl_d, sda_d;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]          shadow [NUM_REGS];
    logic [7:0]          shreg, tx;
    logic [3:0]          bit_cnt;
    logic [7:0]          pointer, ptr_next;
    logic [7:0]          rd_byte, nxt_byte, load_byte;
    logic                sda_oe, rw, ack_bit;
    logic                addr_match, shift_in, load_rd, shift_out, ctrl_wr;

    // ---- stage p0/p1: pin synchronizer, then persistence filter ----
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            scl_p0  <= 1'b1;
            scl_p1  <= 1'b1;
            sda_p0  <= 1'b1;
            sda_p1  <= 1'b1;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            scl_d  <= scl_f;
            sda_d  <= sda_f;
            if (scl_p1 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FCNT_LAST) begin
                scl_f   <= scl_p1;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_p1 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FCNT_LAST) begin
                sda_f   <= sda_p1;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    // ---- bus events on filtered levels ----
    // START/STOP need SCL high on both sides of the SDA edge, so they can
    // never coincide with an SCL edge.
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    assign addr_match = (shreg[7:1] == TARGET_ADDR);
    assign ptr_next   = ptr_inc(pointer);
    assign rd_byte    = shadow[pointer[IDX_W-1:0]];
    assign nxt_byte   = shadow[ptr_next[IDX_W-1:0]];
    assign load_byte  = (state == ADDR_ACK) ? rd_byte : nxt_byte;
    assign shift_in   = scl_rise && (bit_cnt < 4'd8) &&
                        (state == ADDR || state == WR_PTR || state == WR_DATA);
    assign load_rd    = scl_fall && ((state == ADDR_ACK && rw) || (state == RD_ACK && !ack_bit));
    assign shift_out  = scl_fall && (state == RD_DATA) && (bit_cnt != 4'd7);
    assign ctrl_wr    = scl_fall && (state == WR_DATA) && (bit_cnt == 4'd8) && (pointer == CTRL_ADDR);

    // ---- FSM: state register ----
    always_ff @(posedge sys_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else if (scl_fall) begin
            case (state)
                ADDR:     if (bit_cnt == 4'd8) state_next = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK: state_next = rw ? RD_DATA : WR_PTR;
                WR_PTR:   if (bit_cnt == 4'd8) state_next = PTR_ACK;
                PTR_ACK:  state_next = WR_DATA;
                WR_DATA:  if (bit_cnt == 4'd8) state_next = DATA_ACK;
                DATA_ACK: state_next = WR_DATA;
                RD_DATA:  if (bit_cnt == 4'd7) state_next = RD_ACK;
                RD_ACK:   state_next = ack_bit ? WAIT_STOP : RD_DATA;
                default:  state_next = state;
            endcase
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy          = (state != IDLE);
        sda_drive_low = sda_oe;
    end

    // ---- data path: snapshot and shift registers (no reset) ----
    always_ff @(posedge sys_clk) begin
        if (start_det) begin
            for (int k = 0; k < NUM_REGS; k++) shadow[k] <= reg_data_in[8*k +: 8];
        end
        if (shift_in) shreg <= {shreg[6:0], sda_f};
        if (load_rd)        tx <= load_byte;
        else if (shift_out) tx <= {tx[6:0], 1'b0};
    end

    // ---- control path: bit counter, pointer, SDA enable, control byte ----
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sda_oe      <= 1'b0;
            bit_cnt     <= '0;
            pointer     <= '0;
            rw          <= 1'b0;
            ack_bit     <= 1'b1;
            ctrl_reg    <= 8'h00;
            ctrl_strobe <= 1'b0;
        end else begin
            ctrl_strobe <= ctrl_wr;
            if (ctrl_wr) ctrl_reg <= shreg;

            if (start_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                sda_oe <= 1'b0;
            end else if (shift_in) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_rise && state == RD_ACK) begin
                ack_bit <= sda_f;
            end else if (scl_fall) begin
                case (state)
                    ADDR: if (bit_cnt == 4'd8) begin
                        rw     <= shreg[0];
                        sda_oe <= addr_match;
                    end
                    ADDR_ACK: begin
                        bit_cnt <= '0;
                        sda_oe  <= rw ? ~rd_byte[7] : 1'b0;
                    end
                    WR_PTR: if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b1;
                        pointer <= ptr_clamp(shreg);
                    end
                    WR_DATA: if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b1;
                        pointer <= ptr_next;
                    end
                    PTR_ACK, DATA_ACK: begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                    end
                    // Bit 7 went out on the previous fall; the 8th fall ends bit 0.
                    RD_DATA: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        sda_oe  <= (bit_cnt == 4'd7) ? 1'b0 : ~tx[6];
                    end
                    RD_ACK: begin
                        if (!ack_bit) begin
                            pointer <= ptr_next;
                            bit_cnt <= '0;
                            sda_oe  <= ~nxt_byte[7];
                        end else begin
                            sda_oe <= 1'b0;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_telemetry_target.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_i2c_telemetry_target
//
// Directed bench for i2c_telemetry_target. A behavioural host drives SCL and
// an open-drain SDA (wired-AND with the target's pull-down); every host edge
// lands on a falling sys_clk edge so samples are away from the active edge.
// ----------------------------------------------------------------------------
module tb_i2c_telemetry_target;

    localparam int NUM_REGS = 16;
    localparam int Q        = 312;   // quarter of an SCL bit, 12 sys_clk periods

    logic                  sys_clk = 1'b0;
    logic                  reset;
    logic                  scl_m, sda_m;
    logic                  sda_line;
    logic                  sda_drive_low;
    logic [8*NUM_REGS-1:0] reg_data_in;
    logic [7:0]            ctrl_reg;
    logic                  ctrl_strobe;
    logic                  busy;

    int checks      = 0;
    int errors      = 0;
    int host_viol   = 0;
    int strobe_cnt  = 0;
    int drive_cycles = 0;

    always #13 sys_clk = ~sys_clk;

    assign sda_line = sda_m & ~sda_drive_low;

    i2c_telemetry_target #(
        .TARGET_ADDR(7'h42),
        .NUM_REGS   (NUM_REGS),
        .CTRL_ADDR  (8'h0F),
        .FILTER_LEN (4)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .scl_in       (scl_m),
        .sda_in       (sda_line),
        .sda_drive_low(sda_drive_low),
        .reg_data_in  (reg_data_in),
        .ctrl_reg     (ctrl_reg),
        .ctrl_strobe  (ctrl_strobe),
        .busy         (busy)
    );

    always @(posedge sys_clk) begin
        if (ctrl_strobe)   strobe_cnt   <= strobe_cnt + 1;
        if (sda_drive_low) drive_cycles <= drive_cycles + 1;
    end

    // ---- host bus primitives ----
    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    // Host-owned bit: the target must not be pulling SDA at mid-high.
    task automatic write_bit(input logic b);
        sda_m = b;    #(Q);
        scl_m = 1'b1; #(Q);
        if (sda_drive_low) host_viol++;
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic read_bit(input bit glitch, output logic b);
        sda_m = 1'b1;
        if (glitch) begin
            #(Q/2);
            scl_m = 1'b1; #52;
            scl_m = 1'b0; #(Q/2 - 52);
        end else begin
            #(Q);
        end
        scl_m = 1'b1; #(Q);
        b = sda_line;
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(1'b0, a);
        acked = (a == 1'b0);
    endtask

    task automatic read_byte(input logic nack, input int glitch_at, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(i == glitch_at, b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        int d0;
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++; if (sda_drive_low !== 1'b0) begin errors++; $display("FAIL reset_sda: got %b expected 0", sda_drive_low); end
        checks++; if (ctrl_reg !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", ctrl_reg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        d0 = drive_cycles;
        repeat (3850) @(negedge sys_clk);
        checks++; if (drive_cycles - d0 !== 0) begin errors++; $display("FAIL idle_drive: drive cycles %0d expected 0", drive_cycles - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_read_basic();
        logic       acked;
        logic [7:0] d;
        logic [7:0] expv [3];
        logic [7:0] hdr  [2];
        int         v0;
        expv = '{8'hA1, 8'hB2, 8'hC3};
        hdr  = '{8'h84, 8'h03};
        reg_data_in[8*3 +: 8] = 8'hA1;
        reg_data_in[8*4 +: 8] = 8'hB2;
        reg_data_in[8*5 +: 8] = 8'hC3;
        v0 = host_viol;
        @(negedge sys_clk);
        i2c_start();
        for (int i = 0; i < 2; i++) begin
            write_byte(hdr[i], acked);
            checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rd_hdr_ack[%0d]: acked %b expected 1", i, acked); end
        end
        i2c_start();
        write_byte(8'h85, acked);
        checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: acked %b expected 1", acked); end
        for (int i = 0; i < 3; i++) begin
            read_byte(i == 2, -1, d);
            checks++; if (d !== expv[i]) begin errors++; $display("FAIL rd_data[%0d]: got %h expected %h", i, d, expv[i]); end
        end
        checks++; if (sda_drive_low !== 1'b0) begin errors++; $display("FAIL rd_release: got %b expected 0", sda_drive_low); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_pre_stop: got %b expected 1", busy); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_post_stop: got %b expected 0", busy); end
        checks++; if (host_viol !== v0) begin errors++; $display("FAIL rd_host_bit_drive: violations %0d expected %0d", host_viol, v0); end
    endtask

    task automatic test_ctrl_write();
        logic       acked;
        logic [7:0] bytes [3];
        int         s0;
        bytes = '{8'h84, 8'h0F, 8'h5A};
        s0 = strobe_cnt;
        @(negedge sys_clk);
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(bytes[i], acked);
            checks++; if (acked !== 1'b1) begin errors++; $display("FAIL wr_ack[%0d]: acked %b expected 1", i, acked); end
        end
        i2c_stop();
        repeat (4) @(negedge sys_clk);
        checks++; if (ctrl_reg !== 8'h5A) begin errors++; $display("FAIL wr_ctrl_reg: got %h expected 5a", ctrl_reg); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL wr_strobe_count: got %0d expected 1", strobe_cnt - s0); end
    endtask

    task automatic test_addr_nack();
        logic acked;
        int   d0;
        d0 = drive_cycles;
        @(negedge sys_clk);
        i2c_start();
        write_byte(8'h86, acked);
        checks++; if (acked !== 1'b0) begin errors++; $display("FAIL nack_addr: acked %b expected 0", acked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b expected 0", busy); end
        write_byte(8'h84, acked);
        checks++; if (acked !== 1'b0) begin errors++; $display("FAIL nack_follow: acked %b expected 0", acked); end
        i2c_stop();
        checks++; if (drive_cycles - d0 !== 0) begin errors++; $display("FAIL nack_drive: drive cycles %0d expected 0", drive_cycles - d0); end
    endtask

    task automatic test_pointer_wrap_snapshot();
        logic       acked;
        logic [7:0] d;
        logic [7:0] expv [3];
        expv = '{8'hE4, 8'hF5, 8'h10};
        reg_data_in = '0;
        reg_data_in[8*14 +: 8] = 8'hE4;
        reg_data_in[8*15 +: 8] = 8'hF5;
        reg_data_in[8*0  +: 8] = 8'h10;
        @(negedge sys_clk);
        i2c_start();
        write_byte(8'h84, acked);
        write_byte(8'h0E, acked);
        checks++; if (acked !== 1'b1) begin errors++; $display("FAIL wrap_ptr_ack: acked %b expected 1", acked); end
        i2c_start();
        write_byte(8'h85, acked);
        checks++; if (acked !== 1'b1) begin errors++; $display("FAIL wrap_addr_ack: acked %b expected 1", acked); end
        for (int i = 0; i < 3; i++) begin
            read_byte(i == 2, -1, d);
            checks++; if (d !== expv[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, d, expv[i]); end
            if (i == 0) reg_data_in = '1;
        end
        i2c_stop();
    endtask

    task automatic test_scl_glitch();
        logic       acked;
        logic [7:0] d;
        reg_data_in = '0;
        reg_data_in[8*3 +: 8] = 8'hA1;
        reg_data_in[8*4 +: 8] = 8'hB2;
        @(negedge sys_clk);
        i2c_start();
        write_byte(8'h84, acked);
        write_byte(8'h03, acked);
        i2c_start();
        write_byte(8'h85, acked);
        read_byte(1'b0, 3, d);
        checks++; if (d !== 8'hA1) begin errors++; $display("FAIL glitch_byte0: got %h expected a1", d); end
        read_byte(1'b1, 5, d);
        checks++; if (d !== 8'hB2) begin errors++; $display("FAIL glitch_byte1: got %h expected b2", d); end
        i2c_stop();
    endtask

    task automatic test_reset_mid_byte();
        logic acked;
        logic b;
        reg_data_in = '0;
        @(negedge sys_clk);
        i2c_start();
        write_byte(8'h84, acked);
        write_byte(8'h07, acked);
        i2c_start();
        write_byte(8'h85, acked);
        read_bit(1'b0, b);
        checks++; if (sda_drive_low !== 1'b1) begin errors++; $display("FAIL rst_pre_drive: got %b expected 1", sda_drive_low); end
        @(negedge sys_clk);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        checks++; if (sda_drive_low !== 1'b0) begin errors++; $display("FAIL rst_release: got %b expected 0", sda_drive_low); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (ctrl_reg !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got %h expected 00", ctrl_reg); end
        @(negedge sys_clk);
        reset = 1'b0;
        i2c_stop();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        scl_m       = 1'b1;
        sda_m       = 1'b1;
        reg_data_in = '0;
        test_reset();
        test_read_basic();
        test_ctrl_write();
        test_addr_nack();
        test_pointer_wrap_snapshot();
        test_scl_glitch();
        test_reset_mid_byte();
        reg_data_in = '0;
        test_read_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
